// File: rtl/serial_shifter_if.sv
// Request/result bundle for serial_shifter: the master issues start/a/b/dir,
// the slave returns d, busy and done.
interface serial_shifter_if;
  logic       start;
  logic [3:0] a;
  logic [1:0] b;
  logic       dir;
  logic [3:0] d;
  logic       busy;
  logic       done;

  modport master (output start, a, b, dir, input d, busy, done);
  modport slave  (input start, a, b, dir, output d, busy, done);
endinterface

// File: rtl/serial_shifter.sv
// Shifts a 4-bit operand one bit per cycle; done pulses b+1 edges after acceptance.
// No backpressure: start is only honoured in IDLE and ignored while busy.
module serial_shifter (
  input  logic              clk,
  input  logic              rst_n,
  serial_shifter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  logic [3:0] work;
  logic [1:0] cnt;
  logic       dir_q;
  logic [3:0] d_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] shifted;

  always_comb begin
    shifted = dir_q ? {1'b0, work[3:1]} : {work[2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= 4'd0;
      cnt    <= 2'd0;
      dir_q  <= 1'b0;
      d_q    <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= bus.a;
            cnt    <= bus.b;
            dir_q  <= bus.dir;
            busy_q <= 1'b1;
            // A zero shift amount skips SHIFT and publishes the operand as-is.
            if (bus.b == 2'd0) begin
              state  <= DONE;
              d_q    <= bus.a;
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state  <= DONE;
            d_q    <= shifted;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d    = d_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
